// File: rtl/branch_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_flag_unit
// Purpose  : Control-flow stage after the ALU. Latches ALU status flags,
//            resolves conditional/unconditional branches against them (with
//            same-cycle flag forwarding), and keeps a hardware return-address
//            stack for CALL/RET. Produces a registered next-PC for fetch.
// Ports    : clk_i, rst_ni            clock, synchronous active-low reset
//            flag_we_i                capture ALU flags this cycle
//            carry_i, zeroflag_i,
//            msb_i, overflow_i        ALU status outputs
//            instr_valid_i            br_op_i/pc_i/target_i valid
//            br_op_i [3:0]            branch opcode
//            pc_i, target_i           current PC, branch/call destination
//            next_pc_o, taken_o       registered next fetch address / taken
//            out_valid_o              registered: next_pc_o updated
//            flags_o [3:0]            flags register {V,S,C,Z}
//            stack_err_o              sticky return-stack over/underflow
// Revision : 1.0 - initial release
// ============================================================================
module branch_flag_unit #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flag_we_i,
  input  logic            carry_i,
  input  logic            zeroflag_i,
  input  logic            msb_i,
  input  logic            overflow_i,
  input  logic            instr_valid_i,
  input  logic [3:0]      br_op_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            taken_o,
  output logic            out_valid_o,
  output logic [3:0]      flags_o,
  output logic            stack_err_o
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(STACK_DEPTH);

  localparam logic [3:0] OP_BR   = 4'd1;
  localparam logic [3:0] OP_BZ   = 4'd2;
  localparam logic [3:0] OP_BNZ  = 4'd3;
  localparam logic [3:0] OP_BCY  = 4'd4;
  localparam logic [3:0] OP_BNC  = 4'd5;
  localparam logic [3:0] OP_BMI  = 4'd6;
  localparam logic [3:0] OP_BPL  = 4'd7;
  localparam logic [3:0] OP_BV   = 4'd8;
  localparam logic [3:0] OP_BNV  = 4'd9;
  localparam logic [3:0] OP_CALL = 4'd10;
  localparam logic [3:0] OP_RET  = 4'd11;

  logic [PC_W-1:0]  next_pc_q, next_pc_d;
  logic             taken_q, taken_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       flags_q, flags_d;
  logic             stack_err_q, stack_err_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];

  logic [3:0]       alu_flags;
  logic [3:0]       eff_flags;
  logic [PC_W-1:0]  pc_inc;
  logic [PTR_W-1:0] top_ptr;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic             stack_full;
  logic             stack_empty;
  logic             cond_met;
  logic             push;

  assign alu_flags   = {overflow_i, msb_i, carry_i, zeroflag_i};
  // Forward the incoming ALU flags so a branch can test them in the same cycle.
  assign eff_flags   = flag_we_i ? alu_flags : flags_q;
  assign pc_inc      = pc_i + PC_W'(1);
  assign top_ptr     = ptr_q - PTR_W'(1);
  assign top_idx     = top_ptr[IDX_W-1:0];
  assign push_idx    = ptr_q[IDX_W-1:0];
  assign stack_full  = (ptr_q == PTR_FULL);
  assign stack_empty = (ptr_q == '0);

  // Condition evaluation; eff_flags = {V,S,C,Z}.
  always_comb begin
    cond_met = 1'b0;
    case (br_op_i)
      OP_BR:   cond_met = 1'b1;
      OP_BZ:   cond_met =  eff_flags[0];
      OP_BNZ:  cond_met = !eff_flags[0];
      OP_BCY:  cond_met =  eff_flags[1];
      OP_BNC:  cond_met = !eff_flags[1];
      OP_BMI:  cond_met =  eff_flags[2];
      OP_BPL:  cond_met = !eff_flags[2];
      OP_BV:   cond_met =  eff_flags[3];
      OP_BNV:  cond_met = !eff_flags[3];
      default: cond_met = 1'b0;
    endcase
  end

  always_comb begin
    next_pc_d   = next_pc_q;
    taken_d     = taken_q;
    out_valid_d = 1'b0;
    flags_d     = flag_we_i ? alu_flags : flags_q;
    stack_err_d = stack_err_q;
    ptr_d       = ptr_q;
    push        = 1'b0;

    if (instr_valid_i) begin
      out_valid_d = 1'b1;
      next_pc_d   = cond_met ? target_i : pc_inc;
      taken_d     = cond_met;

      if (br_op_i == OP_CALL) begin
        // A CALL always transfers; on a full stack the return address is dropped.
        next_pc_d = target_i;
        taken_d   = 1'b1;
        if (stack_full) begin
          stack_err_d = 1'b1;
        end else begin
          push  = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
        end
      end else if (br_op_i == OP_RET) begin
        if (stack_empty) begin
          stack_err_d = 1'b1;
        end else begin
          next_pc_d = stack_q[top_idx];
          taken_d   = 1'b1;
          ptr_d     = top_ptr;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      next_pc_q   <= '0;
      taken_q     <= 1'b0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
      stack_err_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      next_pc_q   <= next_pc_d;
      taken_q     <= taken_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      stack_err_q <= stack_err_d;
      ptr_q       <= ptr_d;
    end
  end

  // Stack storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign next_pc_o   = next_pc_q;
  assign taken_o     = taken_q;
  assign out_valid_o = out_valid_q;
  assign flags_o     = flags_q;
  assign stack_err_o = stack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_flag_unit
// Purpose  : Self-checking bench for branch_flag_unit. A queue-based model
//            tracks expected outputs every cycle; directed sequences add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_flag_unit;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned STACK_DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flag_we, carry, zeroflag, msb, overflow;
  logic            instr_valid;
  logic [3:0]      br_op;
  logic [PC_W-1:0] pc, target;
  logic [PC_W-1:0] next_pc;
  logic            taken, out_valid, stack_err;
  logic [3:0]      flags;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic [PC_W-1:0] m_next_pc;
  logic            m_taken, m_ov, m_err;
  logic [3:0]      m_flags;
  logic [PC_W-1:0] m_stack [$];

  branch_flag_unit #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flag_we_i     (flag_we),
    .carry_i       (carry),
    .zeroflag_i    (zeroflag),
    .msb_i         (msb),
    .overflow_i    (overflow),
    .instr_valid_i (instr_valid),
    .br_op_i       (br_op),
    .pc_i          (pc),
    .target_i      (target),
    .next_pc_o     (next_pc),
    .taken_o       (taken),
    .out_valid_o   (out_valid),
    .flags_o       (flags),
    .stack_err_o   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the flag conditions and LIFO written from the opcode table.
  always @(posedge clk) begin : model
    logic [3:0] ef;
    logic       cond;
    if (!rst_n) begin
      m_next_pc = '0; m_taken = 1'b0; m_ov = 1'b0; m_flags = '0; m_err = 1'b0;
      m_stack.delete();
    end else begin
      ef = flag_we ? {overflow, msb, carry, zeroflag} : m_flags;
      if (flag_we) m_flags = ef;
      m_ov = instr_valid;
      if (instr_valid) begin
        case (br_op)
          4'd1: cond = 1'b1;
          4'd2: cond = (ef[0] == 1'b1);
          4'd3: cond = (ef[0] == 1'b0);
          4'd4: cond = (ef[1] == 1'b1);
          4'd5: cond = (ef[1] == 1'b0);
          4'd6: cond = (ef[2] == 1'b1);
          4'd7: cond = (ef[2] == 1'b0);
          4'd8: cond = (ef[3] == 1'b1);
          4'd9: cond = (ef[3] == 1'b0);
          default: cond = 1'b0;
        endcase
        m_taken   = cond;
        m_next_pc = cond ? target : pc + 32'd1;
        if (br_op == 4'd10) begin
          m_taken = 1'b1;
          m_next_pc = target;
          if (m_stack.size() == STACK_DEPTH) m_err = 1'b1;
          else m_stack.push_back(pc + 32'd1);
        end else if (br_op == 4'd11) begin
          if (m_stack.size() == 0) m_err = 1'b1;
          else begin
            m_next_pc = m_stack.pop_back();
            m_taken   = 1'b1;
          end
        end
      end
    end
  end

  // Compare process, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model.next_pc",   next_pc,   m_next_pc);
      check("model.taken",     32'(taken),     32'(m_taken));
      check("model.out_valid", 32'(out_valid), 32'(m_ov));
      check("model.flags",     32'(flags),     32'(m_flags));
      check("model.stack_err", 32'(stack_err), 32'(m_err));
    end
  end

  task automatic step(input logic rst, input logic v, input logic [3:0] op,
                      input logic [31:0] p, input logic [31:0] t,
                      input logic fwe, input logic [3:0] f);
    rst_n = rst; instr_valid = v; br_op = op; pc = p; target = t; flag_we = fwe;
    {overflow, msb, carry, zeroflag} = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom, 1'($urandom), 4'($urandom));
  endtask

  logic [3:0]  flag_set [4];
  logic [15:0] take_mask [4];

  initial begin
    // Single-flag patterns and the opcodes that must branch under each.
    flag_set[0] = 4'b0001; take_mask[0] = 16'h02A6; // Z: BR,BZ,BNC,BPL,BNV
    flag_set[1] = 4'b0010; take_mask[1] = 16'h029A; // C: BR,BNZ,BCY,BPL,BNV
    flag_set[2] = 4'b0100; take_mask[2] = 16'h026A; // S: BR,BNZ,BNC,BMI,BNV
    flag_set[3] = 4'b1000; take_mask[3] = 16'h01AA; // V: BR,BNZ,BNC,BPL,BV

    // Reset with random inputs
    do_reset(2);
    chk_en = 1'b1;
    check("rst.next_pc", next_pc, 32'h0);
    check("rst.taken", 32'(taken), 32'h0);
    check("rst.out_valid", 32'(out_valid), 32'h0);
    check("rst.flags", 32'(flags), 32'h0);
    check("rst.stack_err", 32'(stack_err), 32'h0);

    step(1'b1, 1'b1, 4'd11, 32'h50, 32'h99, 1'b0, 4'b0);
    check("ret_empty.next_pc", next_pc, 32'h51);
    check("ret_empty.taken", 32'(taken), 32'h0);
    check("ret_empty.stack_err", 32'(stack_err), 32'h1);

    do_reset(1);
    check("rst2.stack_err", 32'(stack_err), 32'h0);

    // Flag forwarding
    step(1'b1, 1'b1, 4'd2, 32'h10, 32'h40, 1'b1, 4'b0001);
    check("fwd1.next_pc", next_pc, 32'h40);
    check("fwd1.taken", 32'(taken), 32'h1);
    check("fwd1.flags", 32'(flags), 32'h1);
    step(1'b1, 1'b1, 4'd2, 32'h11, 32'h40, 1'b1, 4'b0000);
    check("fwd2.next_pc", next_pc, 32'h12);
    check("fwd2.taken", 32'(taken), 32'h0);

    // Condition sweep
    for (int f = 0; f < 4; f++) begin
      step(1'b1, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, flag_set[f]);
      check("sweep.flags", 32'(flags), 32'(flag_set[f]));
      for (int op = 1; op < 16; op++) begin
        if (op == 10 || op == 11) continue;
        step(1'b1, 1'b1, 4'(op), 32'h1000 + 32'(op), 32'h2000 + 32'(op), 1'b0, 4'b0);
        check($sformatf("sweep.f%0d.op%0d.taken", f, op), 32'(taken), 32'(take_mask[f][op]));
        check($sformatf("sweep.f%0d.op%0d.next_pc", f, op), next_pc,
              take_mask[f][op] ? 32'h2000 + 32'(op) : 32'h1001 + 32'(op));
      end
    end

    // Nested calls
    step(1'b1, 1'b1, 4'd10, 32'h100, 32'h500, 1'b0, 4'b0);
    check("call1.next_pc", next_pc, 32'h500);
    step(1'b1, 1'b1, 4'd10, 32'h200, 32'h600, 1'b0, 4'b0);
    step(1'b1, 1'b1, 4'd10, 32'h300, 32'h700, 1'b0, 4'b0);
    step(1'b1, 1'b1, 4'd11, 32'h900, 32'h0, 1'b0, 4'b0);
    check("ret1.next_pc", next_pc, 32'h301);
    check("ret1.taken", 32'(taken), 32'h1);
    step(1'b1, 1'b1, 4'd11, 32'h901, 32'h0, 1'b0, 4'b0);
    check("ret2.next_pc", next_pc, 32'h201);
    step(1'b1, 1'b1, 4'd11, 32'h902, 32'h0, 1'b0, 4'b0);
    check("ret3.next_pc", next_pc, 32'h101);
    check("nested.stack_err", 32'(stack_err), 32'h0);

    // Overflow: k = 0..STACK_DEPTH
    for (int k = 0; k <= STACK_DEPTH; k++)
      step(1'b1, 1'b1, 4'd10, 32'(k), 32'h800 + 32'(k), 1'b0, 4'b0);
    check("ovf.next_pc", next_pc, 32'h808);
    check("ovf.taken", 32'(taken), 32'h1);
    check("ovf.stack_err", 32'(stack_err), 32'h1);
    for (int k = STACK_DEPTH; k >= 1; k--) begin
      step(1'b1, 1'b1, 4'd11, 32'hA00, 32'h0, 1'b0, 4'b0);
      check($sformatf("ovf.ret%0d", k), next_pc, 32'(k));
    end
    step(1'b1, 1'b1, 4'd11, 32'hB00, 32'h0, 1'b0, 4'b0);
    check("ovf.uflow.next_pc", next_pc, 32'hB01);
    check("ovf.uflow.taken", 32'(taken), 32'h0);

    // Wrap and idle
    step(1'b1, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'h1234, 1'b0, 4'b0);
    check("wrap.next_pc", next_pc, 32'h0);
    check("wrap.out_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'd1, 32'h77, 32'h88, 1'b0, 4'b0);
      check("idle.out_valid", 32'(out_valid), 32'h0);
      check("idle.next_pc", next_pc, 32'h0);
    end

    // Reset with a non-empty stack
    step(1'b1, 1'b1, 4'd10, 32'h40, 32'h400, 1'b0, 4'b0);
    step(1'b1, 1'b1, 4'd10, 32'h41, 32'h410, 1'b0, 4'b0);
    do_reset(1);
    step(1'b1, 1'b1, 4'd11, 32'h60, 32'h0, 1'b0, 4'b0);
    check("rst_stack.next_pc", next_pc, 32'h61);
    check("rst_stack.taken", 32'(taken), 32'h0);
    check("rst_stack.stack_err", 32'(stack_err), 32'h1);

    @(posedge clk);
    chk_en = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_flag_unit.md
# branch_flag_unit

Control-flow stage directly downstream of the ALU in the RISC datapath. It latches the ALU status outputs (carry, zeroflag, msb, overflow) into a flags register and evaluates conditional and unconditional branches against those flags. It also maintains a small hardware return-address stack for CALL/RET. It produces a registered next-PC and taken indication for the fetch stage.

## Interface
- PC_W, 32, program-counter width
- STACK_DEPTH, 8, return-stack entries (power of two, ≥2)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- flag_we  in  1  capture ALU flags this cycle
- carry  in  1  ALU carry out
- zeroflag  in  1  ALU zero flag
- msb  in  1  ALU result sign bit
- overflow  in  1  ALU signed overflow
- instr_valid  in  1  br_op/pc/target valid this cycle
- br_op  in  4  branch opcode (see Operation)
- pc  in  PC_W  address of current instruction
- target  in  PC_W  branch/call destination
- next_pc  out  PC_W  registered next fetch address
- taken  out  1  registered: control transfer taken
- out_valid  out  1  registered: next_pc/taken updated this cycle
- flags  out  4  flags register {V,S,C,Z}
- stack_err  out  1  sticky return-stack over/underflow

## Operation
- Flags register: on flag_we, flags <= {overflow, msb, carry, zeroflag}; otherwise holds.
- Effective flags for evaluation: incoming ALU flags if flag_we is high in the same cycle (forwarding), else the flags register.
- br_op encoding: 0 NOP, 1 BR (always), 2 BZ (Z=1), 3 BNZ (Z=0), 4 BCY (C=1), 5 BNC (C=0), 6 BMI (S=1), 7 BPL (S=0), 8 BV (V=1), 9 BNV (V=0), 10 CALL, 11 RET, 12–15 reserved, treated as NOP.
- Not taken: next_pc = pc+1, taken=0. Taken branch: next_pc = target, taken=1.
- pc+1 is modulo 2^PC_W; pc = all-ones gives 0.
- CALL when stack is not full: push pc+1, next_pc = target, taken=1.
- CALL when stack is full: no push (existing contents are preserved), next_pc = target, taken=1, stack_err set.
- RET when stack is not empty: pop, next_pc = popped value, taken=1.
- RET when stack is empty: next_pc = pc+1, taken=0, stack_err set.
- Stack is LIFO with pointer 0..STACK_DEPTH. full ⇔ ptr=STACK_DEPTH. empty ⇔ ptr=0.
- stack_err is sticky; only reset clears it.
- instr_valid=0: no stack change, out_valid=0 next cycle, next_pc/taken hold their last values. Flags still update on flag_we.

## Timing
- Reset (rst_n=0 at an edge): next_pc=0, taken=0, out_valid=0, flags=0, stack_err=0, stack pointer=0. Stack entry contents are don't-care.
- Reset mid-sequence discards all pending return addresses.
- Latency 1: inputs sampled at edge N; next_pc/taken/out_valid valid after edge N.
- One instruction is accepted per cycle with no stall; back-to-back operation at full rate.
- Push/pop take effect at the accepting edge. A RET in the cycle after a CALL pops that CALL's address.
- Flags written at edge N are visible in the flags output after edge N. An instruction in cycle N sees them through forwarding.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset: hold rst_n=0 two cycles with random inputs -> all outputs 0, stack empty. Then RET -> next_pc=pc+1, taken=0, stack_err=1.
- Flag forwarding: flag_we=1 with zeroflag=1 and BZ pc=0x10 target=0x40 in the same cycle -> next_pc=0x40, taken=1, flags=4'b0001 next cycle. Next cycle, with flag_we=1 and zeroflag=0, BZ pc=0x11 -> next_pc=0x12, taken=0.
- Condition sweep: for each flag value in {V,S,C,Z}, run every br_op 1–9 and 12–15 -> taken matches the encoding table; next_pc is target when taken, else pc+1.
- Nested calls: CALL pc=0x100, 0x200, 0x300 (targets arbitrary), then three RETs -> next_pc 0x301, 0x201, 0x101; stack_err=0.
- Stack overflow: STACK_DEPTH+1 CALLs with pc=k -> last CALL still taken to target and stack_err=1. Then STACK_DEPTH RETs -> return addresses STACK_DEPTH..1 (the pc+1 values of the first STACK_DEPTH CALLs, newest first). Next RET -> not taken.
- Wrap/idle: NOP with pc=0xFFFFFFFF -> next_pc=0. Then instr_valid=0 for 3 cycles -> out_valid=0 and next_pc held at 0. Reset during a non-empty stack -> subsequent RET underflows.
